// File: rtl/lmk_i2c_config.sv
// rtl/lmk_i2c_config.sv - write-only I2C register sequencer for the LMK clock generator
module lmk_i2c_config #(
    parameter int          CLK_DIV     = 125,
    parameter logic [6:0]  SLAVE_ADDR  = 7'h58,
    parameter int          NUM_ENTRIES = 2,
    parameter int          MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] index,
    input  logic [7:0] lut_address,
    input  logic [7:0] lut_data,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [DW-1:0] L_DIV_LAST    = DW'(CLK_DIV - 1);
    localparam logic [RW-1:0] L_MAX_RETRY   = RW'(MAX_RETRY);
    localparam logic [3:0]    L_NUM_ENTRIES = 4'(NUM_ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_BYTE, S_ACK, S_STOP, S_NEXT, S_FIN
    } state_t;

    state_t        r_state;
    logic [3:0]    r_index;
    logic [RW-1:0] r_retry;
    logic          r_load_cyc;
    logic [DW-1:0] r_div;
    logic [1:0]    r_phase;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_addr_byte;
    logic [7:0]    r_data_byte;
    logic          r_nack;
    logic          r_scl_oe;
    logic          r_sda_oe;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    logic          w_qend;
    logic [7:0]    w_next_byte;

    // End of an SCL quarter period, and the byte that follows the current one
    assign w_qend      = (r_div == L_DIV_LAST);
    assign w_next_byte = (r_byte_cnt == 2'd0) ? r_addr_byte : r_data_byte;

    // Sequencer: walks the LUT, frames each write and drives the open-drain enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_index     <= 4'd0;
            r_retry     <= '0;
            r_load_cyc  <= 1'b0;
            r_div       <= '0;
            r_phase     <= 2'd0;
            r_bit       <= 3'd0;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 8'd0;
            r_addr_byte <= 8'd0;
            r_data_byte <= 8'd0;
            r_nack      <= 1'b0;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            // Quarter-period timing runs only while a bus phase is active
            if (r_state == S_START || r_state == S_BYTE ||
                r_state == S_ACK   || r_state == S_STOP) begin
                if (w_qend) begin
                    r_div   <= '0;
                    r_phase <= r_phase + 2'd1;
                end else begin
                    r_div   <= r_div + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_index    <= 4'd1;
                        r_retry    <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_load_cyc <= 1'b0;
                        r_state    <= (NUM_ENTRIES == 0) ? S_FIN : S_LOAD;
                    end
                end

                S_LOAD: begin
                    // First cycle lets the LUT settle on the new index
                    if (!r_load_cyc) begin
                        r_load_cyc <= 1'b1;
                    end else begin
                        r_load_cyc  <= 1'b0;
                        r_shift     <= {SLAVE_ADDR, 1'b0};
                        r_addr_byte <= lut_address;
                        r_data_byte <= lut_data;
                        r_div       <= '0;
                        r_phase     <= 2'd0;
                        r_bit       <= 3'd0;
                        r_byte_cnt  <= 2'd0;
                        r_nack      <= 1'b0;
                        r_state     <= S_START;
                    end
                end

                S_START: begin
                    if (w_qend) begin
                        case (r_phase)
                            2'd1:    r_sda_oe <= 1'b1;
                            2'd2:    r_scl_oe <= 1'b1;
                            2'd3: begin
                                r_sda_oe <= ~r_shift[7];
                                r_state  <= S_BYTE;
                            end
                            default: ;
                        endcase
                    end
                end

                S_BYTE: begin
                    if (w_qend) begin
                        case (r_phase)
                            2'd0:    r_scl_oe <= 1'b0;
                            2'd2:    r_scl_oe <= 1'b1;
                            2'd3: begin
                                if (r_bit == 3'd7) begin
                                    r_bit    <= 3'd0;
                                    r_sda_oe <= 1'b0;
                                    r_state  <= S_ACK;
                                end else begin
                                    r_bit    <= r_bit + 3'd1;
                                    r_shift  <= {r_shift[6:0], 1'b0};
                                    r_sda_oe <= ~r_shift[6];
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_ACK: begin
                    if (w_qend) begin
                        case (r_phase)
                            2'd0:    r_scl_oe <= 1'b0;
                            2'd2: begin
                                r_nack   <= sda_in;
                                r_scl_oe <= 1'b1;
                            end
                            2'd3: begin
                                if (r_nack || r_byte_cnt == 2'd2) begin
                                    r_sda_oe <= 1'b1;
                                    r_state  <= S_STOP;
                                end else begin
                                    r_byte_cnt <= r_byte_cnt + 2'd1;
                                    r_shift    <= w_next_byte;
                                    r_sda_oe   <= ~w_next_byte[7];
                                    r_state    <= S_BYTE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_STOP: begin
                    if (w_qend) begin
                        case (r_phase)
                            2'd0:    r_scl_oe <= 1'b0;
                            2'd1:    r_sda_oe <= 1'b0;
                            2'd3:    r_state  <= S_NEXT;
                            default: ;
                        endcase
                    end
                end

                S_NEXT: begin
                    if (r_nack) begin
                        if (r_retry < L_MAX_RETRY) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_index <= 4'd0;
                            r_state <= S_IDLE;
                        end
                    end else if (r_index == L_NUM_ENTRIES) begin
                        r_state <= S_FIN;
                    end else begin
                        r_index <= r_index + 4'd1;
                        r_retry <= '0;
                        r_state <= S_LOAD;
                    end
                end

                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_index <= 4'd0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign index  = r_index;
    assign scl_oe = r_scl_oe;
    assign sda_oe = r_sda_oe;
    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;

endmodule

// File: tb/tb_lmk_i2c_config.sv
// tb/tb_lmk_i2c_config.sv - randomized self-checking bench with bus decoder and slave model
module tb_lmk_i2c_config;

    localparam int DIV  = 5;
    localparam int NUM  = 2;
    localparam int MAXR = 3;
    localparam int EV_S = 256;
    localparam int EV_P = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] index;
    logic [7:0] lut_address;
    logic [7:0] lut_data;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;
    logic       busy;
    logic       done;
    logic       error;

    logic [7:0] lut_a [16];
    logic [7:0] lut_d [16];
    logic       slave_drive = 1'b0;

    assign lut_address = lut_a[index];
    assign lut_data    = lut_d[index];
    assign sda_in      = ~sda_oe & ~slave_drive;

    always #5 clk = ~clk;

    lmk_i2c_config #(
        .CLK_DIV(DIV), .SLAVE_ADDR(7'h58), .NUM_ENTRIES(NUM), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .index(index),
        .lut_address(lut_address), .lut_data(lut_data),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in),
        .busy(busy), .done(done), .error(error)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    bit plan [64];
    int plan_ptr = 0;
    bit exp_done;
    bit exp_error;
    int n_tx;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic compare_event(input int code);
        int e;
        if (exp_q.size() == 0) begin
            check("unexpected_bus_event", code, -1);
        end else begin
            e = exp_q.pop_front();
            check("bus_event", code, e & 'hFFF);
            check("index_during_frame", int'(index), e >> 12);
        end
    endtask

    // Expected bus traffic for the current plan of slave ACK/NACK answers
    task automatic build_model(output int ntx);
        int p;
        int r;
        bit ok;
        bit nk;
        int b [3];
        p = 0; ntx = 0;
        exp_q.delete();
        exp_done = 1'b0;
        exp_error = 1'b0;
        for (int e = 1; e <= NUM; e++) begin
            r = 0; ok = 1'b0;
            while (!ok) begin
                b[0] = 'hB0; b[1] = int'(lut_a[e]); b[2] = int'(lut_d[e]);
                nk = 1'b0;
                exp_q.push_back(EV_S | (e << 12));
                ntx++;
                for (int k = 0; k < 3 && !nk; k++) begin
                    exp_q.push_back(b[k] | (e << 12));
                    nk = plan[p];
                    p++;
                end
                exp_q.push_back(EV_P | (e << 12));
                if (!nk) ok = 1'b1;
                else if (r < MAXR) r++;
                else begin
                    exp_error = 1'b1;
                    return;
                end
            end
        end
        exp_done = 1'b1;
    endtask

    // mode 0: always ACK, 1: NACK first byte once, 2: always NACK, 3: random NACKs
    task automatic setup(input int mode, input bit fixed_lut);
        if (fixed_lut) begin
            lut_a[1] = 8'h15; lut_d[1] = 8'h02;
            lut_a[2] = 8'h17; lut_d[2] = 8'h32;
        end else begin
            for (int i = 1; i <= NUM; i++) begin
                lut_a[i] = 8'($urandom);
                lut_d[i] = 8'($urandom);
            end
        end
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       plan[i] = 1'b0;
                1:       plan[i] = (i == 0);
                2:       plan[i] = 1'b1;
                default: plan[i] = ($urandom_range(0, 3) == 0);
            endcase
        end
        plan_ptr = 0;
        build_model(n_tx);
    endtask

    task automatic go(input bit poke, input int exp_lat);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("done_cleared_on_start", int'(done), 0);
        check("error_cleared_on_start", int'(error), 0);
        check("index_first_entry", int'(index), 1);
        cyc = 0;
        while (busy && cyc < 20000) begin
            start = poke && (cyc == 300);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("sequence_timeout", int'(busy), 0);
        if (exp_lat >= 0) check("sequence_latency", cyc, exp_lat);
        check("done_final", int'(done), int'(exp_done));
        check("error_final", int'(error), int'(exp_error));
        check("index_idle", int'(index), 0);
        check("events_left", exp_q.size(), 0);
    endtask

    // Bus decoder, slave ACK driver, and SCL timing / SDA stability monitor
    bit prev_scl = 1'b1, prev_sda = 1'b1, prev_sda_oe = 1'b0;
    bit in_frame = 1'b0, hi_valid = 1'b0, lo_valid = 1'b0;
    int bitcnt = 0;
    int run = 1;
    logic [7:0] cur = 8'd0;

    always @(negedge clk) begin
        bit scl;
        bit sda;
        scl = ~scl_oe;
        sda = ~sda_oe & ~slave_drive;
        if (rst) begin
            in_frame = 1'b0; hi_valid = 1'b0; lo_valid = 1'b0;
            bitcnt = 0; slave_drive = 1'b0; run = 1;
        end else begin
            if (scl != prev_scl) begin
                check("scl_sda_same_cycle", int'(sda_oe), int'(prev_sda_oe));
            end
            if (scl && !prev_scl) begin
                if (lo_valid) check("scl_low_time", run, 2 * DIV);
                hi_valid = in_frame;
                if (in_frame) begin
                    bitcnt++;
                    if (bitcnt <= 8) cur = {cur[6:0], sda};
                    else begin
                        compare_event(int'(cur));
                        bitcnt = 0;
                    end
                end
                run = 1;
            end else if (!scl && prev_scl) begin
                if (hi_valid) check("scl_high_time", run, 2 * DIV);
                lo_valid = in_frame;
                if (in_frame && bitcnt == 8) begin
                    slave_drive = (plan_ptr < 64) ? !plan[plan_ptr] : 1'b0;
                    plan_ptr++;
                end else if (bitcnt == 0) begin
                    slave_drive = 1'b0;
                end
                run = 1;
            end else begin
                run++;
                if (scl && prev_scl && sda != prev_sda) begin
                    if (!sda) begin
                        compare_event(EV_S);
                        in_frame = 1'b1;
                        bitcnt = 0;
                    end else begin
                        compare_event(EV_P);
                        in_frame = 1'b0;
                        hi_valid = 1'b0;
                        lo_valid = 1'b0;
                    end
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda;
        prev_sda_oe = sda_oe;
    end

    initial begin
        int lit [10];
        int cnt;
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lut_a[i] = 8'($urandom);
            lut_d[i] = 8'($urandom);
        end
        repeat (3) @(negedge clk);
        check("reset_scl_oe", int'(scl_oe), 0);
        check("reset_sda_oe", int'(sda_oe), 0);
        check("reset_index", int'(index), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_error", int'(error), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal two-entry write; model pinned against hand-decoded traffic
        setup(0, 1'b1);
        lit = '{EV_S | (1 << 12), 'hB0 | (1 << 12), 'h15 | (1 << 12), 'h02 | (1 << 12), EV_P | (1 << 12),
                EV_S | (2 << 12), 'hB0 | (2 << 12), 'h17 | (2 << 12), 'h32 | (2 << 12), EV_P | (2 << 12)};
        check("model_nominal_len", exp_q.size(), 10);
        for (int i = 0; i < 10 && i < exp_q.size(); i++) check("model_nominal_event", exp_q[i], lit[i]);
        go(1'b0, 1167);

        // Start after done: done must clear on the accepting edge
        check("done_before_restart", int'(done), 1);
        setup(1, 1'b1);
        check("model_nack_once_tx", n_tx, 3);
        go(1'b0, -1);

        // Permanent NACK: 1 + MAX_RETRY attempts of entry 1, then error
        setup(2, 1'b1);
        check("model_always_nack_tx", n_tx, 4);
        check("model_always_nack_error", int'(exp_error), 1);
        go(1'b0, -1);

        // Start pulsed mid-transfer must not disturb the stream
        setup(3, 1'b0);
        go(1'b1, -1);

        // Reset during bit 4 of the register-address byte
        setup(0, 1'b0);
        cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!(in_frame && exp_q.size() == 8 && bitcnt == 4) && cnt < 5000) begin
            @(posedge clk);
            #2;
            cnt++;
        end
        check("reset_point_reached", int'(cnt < 5000), 1);
        rst = 1'b1;
        #1;
        check("async_reset_scl_oe", int'(scl_oe), 0);
        check("async_reset_sda_oe", int'(sda_oe), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_index", int'(index), 0);
        check("async_reset_done", int'(done), 0);
        check("async_reset_error", int'(error), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        setup(0, 1'b1);
        go(1'b0, 1167);

        // Randomized LUT contents and slave answers
        for (int t = 0; t < 4; t++) begin
            setup(3, 1'b0);
            go(1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
